core_inst_sequencer: RTL and testbench



---
 rtl/core_inst_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_sequencer.sv
// Instruction-bus initiator for the PE core: walks every kij pass of a tile, then the psum readout.
// Optional drain watchdog and READ debug flag: define CTRL_DRAIN_WDOG_EN.

module core_inst_sequencer #(
   parameter int col     = 8,
   parameter int row     = 8,
   parameter int len_nij = 36,
   parameter int in_w    = 6,
   parameter int k_w     = 3,
   parameter int out_w   = 4,
   parameter int w_base  = 1024,
   parameter int gap_cyc = 10,
   parameter int rst_cyc = 10,
   parameter int timeout = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [63:0] inst,
   output logic        core_reset,
   output logic        busy,
   output logic        done,
   output logic [3:0]  kij_idx,
   output logic        err
);

   // state   | meaning
   // IDLE    | waiting for start
   // CRST    | per-pass core reset, then one released cycle
   // WFILL   | weights xmem -> L0, then one idle cycle
   // KLOAD   | L0 -> PE kernel load
   // GAP     | settle before execute
   // EXEC    | activations streamed, drain running alongside
   // DRAIN   | waiting for the remaining OFIFO rows
   // FLUSH   | two pmem-idle cycles, then next kij or readout
   // READ    | pmem readout of all output pixels
   // DONE    | one-cycle done pulse
   typedef enum logic [3:0] {
      S_IDLE, S_CRST, S_WFILL, S_KLOAD, S_GAP,
      S_EXEC, S_DRAIN, S_FLUSH, S_READ, S_DONE
   } state_t;

   localparam int LEN_KIJ  = k_w * k_w;
   localparam int LEN_ONIJ = out_w * out_w;

   localparam logic [7:0]        RST_C    = 8'(rst_cyc);
   localparam logic [7:0]        WFILL_C  = 8'(col + 1);
   localparam logic [7:0]        KLOAD_C  = 8'(col + row);
   localparam logic [7:0]        GAP_C    = 8'(gap_cyc - 1);
   localparam logic [7:0]        EXEC_C   = 8'(len_nij - 1);
   localparam logic [7:0]        READ_C   = 8'(LEN_ONIJ - 1);
   localparam logic [7:0]        NIJ_C    = 8'(len_nij);
   localparam logic [3:0]        KIJ_LAST = 4'(LEN_KIJ - 1);
   localparam logic [3:0]        KW_LAST  = 4'(k_w - 1);
   localparam logic [3:0]        INW_LAST = 4'(in_w - 1);
   localparam logic signed [4:0] OUTW_S   = 5'(out_w);
   localparam logic [10:0]       WBASE_A  = 11'(w_base);
   localparam logic [10:0]       COL_A    = 11'(col);
   localparam logic [10:0]       OUTW_A   = 11'(out_w);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        kij_q, kij_d;
   logic [3:0]        kx_q, kx_d, ky_q, ky_d;
   logic [3:0]        x_q, x_d;
   logic [7:0]        nij_q, nij_d;
   logic signed [4:0] ox_q, ox_d, oy_q, oy_d;
   logic              err_q, err_d;
   logic              wdog_hit;

   logic        load_q, load_d, exec_q, exec_d, l0wr_q, l0wr_d, l0rd_q, l0rd_d;
   logic [10:0] axm_q, axm_d;
   logic        wenx_q, wenx_d, cenx_q, cenx_d, dbg_q, dbg_d;
   logic        crst_q, crst_d, busy_q, busy_d, done_q, done_d;

   logic        drain_en, in_win, ofifo_rd;
   logic        cen_p, wen_p, acc, pass;
   logic [10:0] a_p, wr_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         kij_q   <= '0;
         kx_q    <= '0;
         ky_q    <= '0;
         x_q     <= '0;
         nij_q   <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         err_q   <= 1'b0;
         load_q  <= 1'b0;
         exec_q  <= 1'b0;
         l0wr_q  <= 1'b0;
         l0rd_q  <= 1'b0;
         axm_q   <= '0;
         wenx_q  <= 1'b1;
         cenx_q  <= 1'b1;
         dbg_q   <= 1'b0;
         crst_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kij_q   <= kij_d;
         kx_q    <= kx_d;
         ky_q    <= ky_d;
         x_q     <= x_d;
         nij_q   <= nij_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         err_q   <= err_d;
         load_q  <= load_d;
         exec_q  <= exec_d;
         l0wr_q  <= l0wr_d;
         l0rd_q  <= l0rd_d;
         axm_q   <= axm_d;
         wenx_q  <= wenx_d;
         cenx_q  <= cenx_d;
         dbg_q   <= dbg_d;
         crst_q  <= crst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef CTRL_DRAIN_WDOG_EN
   logic [7:0] wdog_q, wdog_d;

   always_ff @(posedge clk) begin
      if (reset) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end

   always_comb begin
      wdog_d = wdog_q + 8'd1;
      if (ofifo_valid || state_q != S_DRAIN) wdog_d = '0;
   end

   assign wdog_hit = (state_q == S_DRAIN) && !ofifo_valid && (wdog_q == 8'(timeout - 1));
`else
   assign wdog_hit = 1'b0;
`endif

   assign err_d = err_q | wdog_hit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kij_d   = kij_q;
      kx_d    = kx_q;
      ky_d    = ky_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CRST;
               cnt_d   = RST_C;
            end
         end
         S_CRST: begin
            if (cnt_q == 8'd0) begin
               state_d = S_WFILL;
               cnt_d   = WFILL_C;
            end else cnt_d = cnt_q - 8'd1;
         end
         S_WFILL: begin
            if (cnt_q == 8'd0) begin
               state_d = S_KLOAD;
               cnt_d   = KLOAD_C;
            end else cnt_d = cnt_q - 8'd1;
         end
         S_KLOAD: begin
            if (cnt_q == 8'd0) begin
               state_d = S_GAP;
               cnt_d   = GAP_C;
            end else cnt_d = cnt_q - 8'd1;
         end
         S_GAP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_EXEC;
               cnt_d   = EXEC_C;
            end else cnt_d = cnt_q - 8'd1;
         end
         S_EXEC: begin
            if (cnt_q == 8'd0) state_d = S_DRAIN;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_DRAIN: begin
            if (nij_q == NIJ_C || wdog_hit) begin
               state_d = S_FLUSH;
               cnt_d   = 8'd1;
            end
         end
         S_FLUSH: begin
            if (cnt_q == 8'd0) begin
               kij_d = kij_q + 4'd1;
               // kernel offsets tracked incrementally so the drain needs no divider
               if (kx_q == KW_LAST) begin
                  kx_d = '0;
                  ky_d = ky_q + 4'd1;
               end else kx_d = kx_q + 4'd1;
               if (kij_q == KIJ_LAST) begin
                  state_d = S_READ;
                  cnt_d   = READ_C;
               end else begin
                  state_d = S_CRST;
                  cnt_d   = RST_C;
               end
            end else cnt_d = cnt_q - 8'd1;
         end
         S_READ: begin
            if (cnt_q == 8'd0) begin
               state_d = S_DONE;
               kij_d   = '0;
               kx_d    = '0;
               ky_d    = '0;
            end else cnt_d = cnt_q - 8'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign drain_en = (state_q == S_EXEC || state_q == S_DRAIN) && (nij_q != NIJ_C) && ofifo_valid;
   assign in_win   = (ox_q >= 5'sd0) && (ox_q < OUTW_S) && (oy_q >= 5'sd0) && (oy_q < OUTW_S);
   assign wr_addr  = {7'd0, ox_q[3:0]} + {7'd0, oy_q[3:0]} * OUTW_A;

   always_comb begin
      x_d   = x_q;
      nij_d = nij_q;
      ox_d  = ox_q;
      oy_d  = oy_q;
      if (state_q == S_CRST) begin
         x_d   = '0;
         nij_d = '0;
         ox_d  = 5'sd0 - $signed({1'b0, kx_q});
         oy_d  = 5'sd0 - $signed({1'b0, ky_q});
      end else if (drain_en) begin
         nij_d = nij_q + 8'd1;
         if (x_q == INW_LAST) begin
            x_d  = '0;
            ox_d = 5'sd0 - $signed({1'b0, kx_q});
            oy_d = oy_q + 5'sd1;
         end else begin
            x_d  = x_q + 4'd1;
            ox_d = ox_q + 5'sd1;
         end
      end
   end

   always_comb begin
      ofifo_rd = 1'b0;
      cen_p    = 1'b1;
      wen_p    = 1'b0;
      a_p      = '0;
      acc      = 1'b0;
      pass     = 1'b0;
      if (drain_en) begin
         ofifo_rd = 1'b1;
         if (in_win) begin
            cen_p = 1'b0;
            wen_p = 1'b1;
            a_p   = wr_addr;
            pass  = (kij_q == 4'd0);
            acc   = (kij_q != 4'd0);
         end
      end else if (state_q == S_READ) begin
         cen_p = 1'b0;
         a_p   = {3'd0, READ_C - cnt_q};
      end
   end

   // registered fields are decoded from the next state so they line up with state_q
   always_comb begin
      load_d = 1'b0;
      exec_d = 1'b0;
      l0wr_d = 1'b0;
      l0rd_d = 1'b0;
      axm_d  = '0;
      wenx_d = 1'b1;
      cenx_d = 1'b1;
      dbg_d  = 1'b0;
      crst_d = 1'b0;
      busy_d = !(state_d == S_IDLE || state_d == S_DONE);
      done_d = (state_d == S_DONE);
      case (state_d)
         S_CRST:  crst_d = (cnt_d != 8'd0);
         S_WFILL: begin
            if (cnt_d != 8'd0) begin
               cenx_d = 1'b0;
               l0wr_d = 1'b1;
               axm_d  = WBASE_A + {7'd0, kij_d} * COL_A + {3'd0, WFILL_C - cnt_d};
            end
         end
         S_KLOAD: begin
            l0rd_d = 1'b1;
            load_d = (cnt_d != KLOAD_C);
         end
         S_EXEC: begin
            cenx_d = 1'b0;
            l0wr_d = 1'b1;
            l0rd_d = 1'b1;
            exec_d = 1'b1;
            axm_d  = {3'd0, EXEC_C - cnt_d};
         end
`ifdef CTRL_DRAIN_WDOG_EN
         S_READ:  dbg_d = 1'b1;
`endif
         default: ;
      endcase
   end

   always_comb begin
      inst        = '0;
      inst[0]     = load_q;
      inst[1]     = exec_q;
      inst[2]     = l0wr_q;
      inst[3]     = l0rd_q;
      inst[6]     = ofifo_rd;
      inst[17:7]  = axm_q;
      inst[18]    = wenx_q;
      inst[19]    = cenx_q;
      inst[30:20] = a_p;
      inst[31]    = wen_p;
      inst[32]    = cen_p;
      inst[33]    = acc;
      inst[34]    = pass;
      inst[63]    = dbg_q;
   end

   assign core_reset = crst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign kij_idx    = kij_q;
   assign err        = err_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Scoreboard bench for core_inst_sequencer: reference expectations queued at start, monitor pops on bus events.
// Build with CTRL_DRAIN_WDOG_EN to exercise the drain watchdog (timeout overridden to 20).

module tb_core_inst_sequencer;

   localparam int COL      = 8;
   localparam int LEN_NIJ  = 36;
   localparam int IN_W     = 6;
   localparam int K_W      = 3;
   localparam int OUT_W    = 4;
   localparam int W_BASE   = 1024;
   localparam int LEN_KIJ  = K_W * K_W;
   localparam int LEN_ONIJ = OUT_W * OUT_W;
   localparam int TMO      = 20;
`ifdef CTRL_DRAIN_WDOG_EN
   localparam bit DBG_EXP  = 1'b1;
`else
   localparam bit DBG_EXP  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        ofifo_valid = 1'b0;
   logic [63:0] inst;
   logic        core_reset, busy, done, err;
   logic [3:0]  kij_idx;

   core_inst_sequencer #(.timeout(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .core_reset  (core_reset),
      .busy        (busy),
      .done        (done),
      .kij_idx     (kij_idx),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct { int kij; bit wr; int addr; } drain_t;
   typedef struct { int addr; bit ex; } xrec_t;

   drain_t dq[$];
   xrec_t  xq[$];
   int     rq[$];
   drain_t md;
   xrec_t  mx;
   int     mr;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   int vmode  = 0;
   int crst_run = 0, load_run = 0, done_cnt = 0, rsv_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Reference: each pass fills 9 weight rows, streams 36 activations, then maps every
   // drained row (x,y) to output pixel (x-kx, y-ky) when that lands inside the out_w window.
   task automatic push_run();
      for (int k = 0; k < LEN_KIJ; k++) begin
         for (int i = 0; i <= COL; i++) xq.push_back('{addr: W_BASE + k * COL + i, ex: 1'b0});
         for (int n = 0; n < LEN_NIJ; n++) xq.push_back('{addr: n, ex: 1'b1});
         for (int n = 0; n < LEN_NIJ; n++) begin
            int ox, oy;
            bit wr;
            ox = (n % IN_W) - (k % K_W);
            oy = (n / IN_W) - (k / K_W);
            wr = (ox >= 0) && (ox < OUT_W) && (oy >= 0) && (oy < OUT_W);
            dq.push_back('{kij: k, wr: wr, addr: wr ? ox + oy * OUT_W : 0});
         end
      end
      for (int a = 0; a < LEN_ONIJ; a++) rq.push_back(a);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic apply_reset(input int n);
      @(posedge clk); #1 reset = 1'b1;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return inst[1] == 1'b1;
         1:       return inst[1] == 1'b0;
         2:       return done == 1'b1;
         3:       return kij_idx == 4'd2;
         4:       return kij_idx == 4'd3;
         default: return err == 1'b1;
      endcase
   endfunction

   task automatic wait_for(input int which, input int budget, input string name);
      int n = 0;
      while (!cond(which) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!cond(which)) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: waited %0d cycles, condition not reached", name, budget);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (vmode)
            1:       ofifo_valid = ($urandom_range(0, 9) < 7);
            2:       ofifo_valid = (kij_idx == 4'd2) ? 1'b0 : ($urandom_range(0, 9) < 7);
            default: ofifo_valid = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (mon_en) begin
         if (inst[5:4] != 2'b00 || inst[35] || inst[62:36] != '0) rsv_bad++;
         if (inst[6]) begin
            if (dq.size() == 0) check("drain_extra_row", 64'd1, 64'd0);
            else begin
               md = dq.pop_front();
               check("drain_kij", 64'(kij_idx), 64'(md.kij));
               check("drain_cen_pmem", 64'(inst[32]), 64'(!md.wr));
               if (md.wr) begin
                  check("drain_a_pmem", 64'(inst[30:20]), 64'(md.addr));
                  check("drain_wen_pmem", 64'(inst[31]), 64'd1);
                  check("drain_passthrough", 64'(inst[34]), 64'(md.kij == 0));
                  check("drain_acc", 64'(inst[33]), 64'(md.kij != 0));
               end
            end
         end else if (!inst[32]) begin
            check("read_wen_pmem", 64'(inst[31]), 64'd0);
            if (rq.size() == 0) check("read_extra", 64'd1, 64'd0);
            else begin
               mr = rq.pop_front();
               check("read_a_pmem", 64'(inst[30:20]), 64'(mr));
               check("read_debug", 64'(inst[63]), 64'(DBG_EXP));
            end
         end
         if (!inst[19]) begin
            if (xq.size() == 0) check("xmem_extra", 64'd1, 64'd0);
            else begin
               mx = xq.pop_front();
               check("xmem_addr", 64'(inst[17:7]), 64'(mx.addr));
               check("xmem_execute", 64'(inst[1]), 64'(mx.ex));
               check("xmem_l0_rd", 64'(inst[3]), 64'(mx.ex));
               check("xmem_l0_wr", 64'(inst[2]), 64'd1);
               check("xmem_wen", 64'(inst[18]), 64'd1);
            end
         end
         if (core_reset) crst_run++;
         else if (crst_run != 0) begin
            check("core_reset_len", 64'(crst_run), 64'd10);
            crst_run = 0;
         end
         if (inst[0]) begin
            load_run++;
            check("load_l0_rd", 64'(inst[3]), 64'd1);
         end else if (load_run != 0) begin
            check("load_len", 64'(load_run), 64'd16);
            load_run = 0;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_inst", inst, 64'h0000_0001_000C_0000);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_core_reset", 64'(core_reset), 64'd0);
      check("rst_kij", 64'(kij_idx), 64'd0);
      check("rst_err", 64'(err), 64'd0);

      // abort in the middle of EXEC
      pulse_start();
      wait_for(0, 200, "exec_for_abort");
      repeat (5) @(negedge clk);
      apply_reset(3);
      @(negedge clk);
      check("abort_inst", inst, 64'h0000_0001_000C_0000);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_core_reset", 64'(core_reset), 64'd0);
      repeat (20) @(negedge clk);
      check("abort_stays_idle", 64'(busy), 64'd0);
      check("abort_idle_inst", inst, 64'h0000_0001_000C_0000);

      // full tile with randomly paced OFIFO
      done_cnt = 0;
      push_run();
      mon_en = 1'b1;
      vmode  = 1;
      pulse_start();
      repeat (200) @(posedge clk);
      pulse_start();
      wait_for(2, 20000, "done");
      check("done_kij_wrap", 64'(kij_idx), 64'd0);
      check("done_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      repeat (5) @(negedge clk);
      mon_en = 1'b0;
      check("done_count", 64'(done_cnt), 64'd1);
      check("drain_queue_empty", 64'(dq.size()), 64'd0);
      check("xmem_queue_empty", 64'(xq.size()), 64'd0);
      check("read_queue_empty", 64'(rq.size()), 64'd0);
      check("reserved_bits", 64'(rsv_bad), 64'd0);
      check("idle_err", 64'(err), 64'd0);

      // OFIFO silent for the whole of kij2
      vmode = 2;
      pulse_start();
      wait_for(3, 2000, "kij2");
      wait_for(0, 200, "kij2_exec");
      wait_for(1, 200, "kij2_drain");
`ifdef CTRL_DRAIN_WDOG_EN
      begin
         int n = 0;
         while (!err && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("wdog_latency", 64'(n), 64'(TMO));
      end
      wait_for(4, 50, "kij3_after_wdog");
      check("wdog_kij_advance", 64'(kij_idx), 64'd3);
      check("wdog_err_sticky", 64'(err), 64'd1);
`else
      repeat (300) @(negedge clk);
      check("stuck_busy", 64'(busy), 64'd1);
      check("stuck_kij", 64'(kij_idx), 64'd2);
      check("stuck_err", 64'(err), 64'd0);
      check("stuck_no_exec", 64'(inst[1]), 64'd0);
      check("stuck_cen_xmem", 64'(inst[19]), 64'd1);
`endif
      vmode = 0;
      apply_reset(2);
      @(negedge clk);
      check("final_rst_err", 64'(err), 64'd0);
      check("final_rst_busy", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
